// File: rtl/imem_debug_loader.sv
// Byte-stream loader for the instruction RAM debug port: packs host bytes into words and writes them.
// Optional readback verification is enabled by defining IMEM_LOADER_VERIFY_EN.
module imem_debug_loader #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned HOLD_ON_ERROR = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic [31:0]      dbg_addr,
    output logic [31:0]      dbg_wdata,
    output logic [3:0]       dbg_we,
    input  logic [31:0]      dbg_rdata,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      err_addr,
    output logic [CNT_W-1:0] words_written,
    output logic             cpu_hold
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
`ifdef IMEM_LOADER_VERIFY_EN
        ,
        READ,
        CMP,
        ERROR
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      base_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       byte_cnt_q;
    logic [31:0]      word_q, word_c;
    logic             start_ok_c, beat_c, busy_d, hold_d;

    // Next-state decode; the incoming byte is merged into word_c so WRITE sees the full word.
    always_comb begin
        state_d    = state_q;
        start_ok_c = 1'b0;
        beat_c     = 1'b0;
        word_c     = word_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_ok_c = 1'b1;
                    state_d    = (word_count == '0) ? DONE : COLLECT;
                end
            end
`ifdef IMEM_LOADER_VERIFY_EN
            ERROR: begin
                if (start) begin
                    start_ok_c = 1'b1;
                    state_d    = (word_count == '0) ? DONE : COLLECT;
                end
            end
            READ: state_d = CMP;
            CMP: begin
                if (dbg_rdata != dbg_wdata) begin
                    state_d = ERROR;
                end else begin
                    state_d = (words_written == cnt_q) ? DONE : COLLECT;
                end
            end
`endif
            COLLECT: begin
                if (in_valid && in_ready) begin
                    beat_c = 1'b1;
                    word_c[{byte_cnt_q, 3'b000} +: 8] = in_data;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
`ifdef IMEM_LOADER_VERIFY_EN
                state_d = READ;
`else
                state_d = (words_written + CNT_W'(1) == cnt_q) ? DONE : COLLECT;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Status flags decoded from the next state so they line up with the state register.
    always_comb begin
        busy_d = (state_d == COLLECT) || (state_d == WRITE);
`ifdef IMEM_LOADER_VERIFY_EN
        busy_d = busy_d || (state_d == READ) || (state_d == CMP);
`endif
        hold_d = busy_d;
`ifdef IMEM_LOADER_VERIFY_EN
        if ((state_d == ERROR) && (HOLD_ON_ERROR != 0)) begin
            hold_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            base_q        <= '0;
            cnt_q         <= '0;
            byte_cnt_q    <= '0;
            word_q        <= '0;
            in_ready      <= 1'b0;
            dbg_addr      <= '0;
            dbg_wdata     <= '0;
            dbg_we        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cpu_hold      <= 1'b0;
            words_written <= '0;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d == COLLECT);
            dbg_we   <= (state_d == WRITE) ? 4'b1111 : 4'b0000;
            busy     <= busy_d;
            done     <= (state_d == DONE);
            cpu_hold <= hold_d;
            word_q   <= word_c;
            if (start_ok_c) begin
                base_q        <= {base_addr[31:2], 2'b00};
                cnt_q         <= word_count;
                byte_cnt_q    <= '0;
                words_written <= '0;
            end
            if (beat_c) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end
            if (state_q == COLLECT && state_d == WRITE) begin
                dbg_addr  <= base_q + (32'(words_written) << 2);
                dbg_wdata <= word_c;
            end
            if (state_q == WRITE) begin
                words_written <= words_written + CNT_W'(1);
            end
        end
    end

`ifdef IMEM_LOADER_VERIFY_EN
    // Sticky error status; err_addr captures the word whose readback disagreed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error    <= 1'b0;
            err_addr <= '0;
        end else begin
            error <= (state_d == ERROR);
            if (start_ok_c) begin
                err_addr <= '0;
            end else if (state_q == CMP && state_d == ERROR) begin
                err_addr <= dbg_addr;
            end
        end
    end
`else
    logic unused_sig;
    assign unused_sig = ^{dbg_rdata, 1'(HOLD_ON_ERROR)};
    assign error      = 1'b0;
    assign err_addr   = '0;
`endif

endmodule

// File: tb/tb_imem_debug_loader.sv
// Directed bench for imem_debug_loader: load, zero count, throttling, wrap, reset and optional verify.
module tb_imem_debug_loader;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [31:0]      base_addr;
    logic [CNT_W-1:0] word_count;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic [31:0]      dbg_addr;
    logic [31:0]      dbg_wdata;
    logic [3:0]       dbg_we;
    logic [31:0]      dbg_rdata;
    logic             busy;
    logic             done;
    logic             error;
    logic [31:0]      err_addr;
    logic [CNT_W-1:0] words_written;
    logic             cpu_hold;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imem_debug_loader #(.CNT_W(CNT_W), .HOLD_ON_ERROR(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_we(dbg_we), .dbg_rdata(dbg_rdata), .busy(busy), .done(done),
        .error(error), .err_addr(err_addr), .words_written(words_written),
        .cpu_hold(cpu_hold)
    );

    // RAM model with synchronous read and an optional stuck bit at 0x24.
    logic [31:0] mem [logic [31:0]];
    logic        corrupt_en = 1'b0;
    always @(posedge clk) begin
        if (dbg_we == 4'hF) mem[dbg_addr] = dbg_wdata;
        dbg_rdata <= (mem.exists(dbg_addr) ? mem[dbg_addr] : 32'h0)
                     ^ ((corrupt_en && dbg_addr == 32'h24) ? 32'h1 : 32'h0);
    end

    // Write log sampled mid-cycle.
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [3:0]  wr_we_q   [$];
    always @(negedge clk) begin
        if (dbg_we != 4'h0) begin
            wr_addr_q.push_back(dbg_addr);
            wr_data_q.push_back(dbg_wdata);
            wr_we_q.push_back(dbg_we);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_we_q.delete();
    endtask

    task automatic do_start(input logic [31:0] b, input logic [CNT_W-1:0] n);
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] t;
            t = w >> (8 * k);
            send_byte(t[7:0]);
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(done), 32'h1);
    endtask

    task automatic check_write(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
        if (wr_addr_q.size() > idx) begin
            check({tag, "_addr"}, wr_addr_q[idx], a);
            check({tag, "_data"}, wr_data_q[idx], d);
            check({tag, "_we"}, 32'(wr_we_q[idx]), 32'hF);
        end else begin
            check({tag, "_present"}, 32'(wr_addr_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        in_valid = 1'b0; in_data = '0;
        #12;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_err_addr", err_addr, 32'h0);
        check("rst_we", 32'(dbg_we), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h0);
        check("rst_hold", 32'(cpu_hold), 32'h0);
        check("rst_ww", 32'(words_written), 32'h0);
        check("rst_addr", dbg_addr, 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic two-word load
        clear_log();
        do_start(32'h10, 16'd2);
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_hold", 32'(cpu_hold), 32'h1);
        check("t1_ready", 32'(in_ready), 32'h1);
        send_word(32'h00000013);
        check("t1_we0", 32'(dbg_we), 32'hF);
        check("t1_addr0", dbg_addr, 32'h10);
        check("t1_wdata0", dbg_wdata, 32'h00000013);
        check("t1_ready_wr", 32'(in_ready), 32'h0);
        send_word(32'h00100093);
        wait_done("t1_done");
        check("t1_hold_off", 32'(cpu_hold), 32'h0);
        check("t1_busy_off", 32'(busy), 32'h0);
        check("t1_ww", 32'(words_written), 32'h2);
        check("t1_nwr", 32'(wr_addr_q.size()), 32'h2);
        check_write("t1_w0", 0, 32'h10, 32'h00000013);
        check_write("t1_w1", 1, 32'h14, 32'h00100093);

        // Zero count, then misaligned base
        clear_log();
        do_start(32'h3, 16'd0);
        check("t2_done_now", 32'(done), 32'h1);
        check("t2_busy", 32'(busy), 32'h0);
        check("t2_ww", 32'(words_written), 32'h0);
        tick(); tick();
        check("t2_nowrite", 32'(wr_addr_q.size()), 32'h0);
        do_start(32'h7, 16'd1);
        check("t2_done_clr", 32'(done), 32'h0);
        send_word(32'hDDCCBBAA);
        wait_done("t2_done1");
        check_write("t2_w0", 0, 32'h4, 32'hDDCCBBAA);

        // Throttled host with a stray start mid-load
        clear_log();
        do_start(32'h100, 16'd1);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] bv;
            bv = 8'h51 + 8'(k);
            in_valid = 1'b0;
            tick();
            check("t3_ready_hold", 32'(in_ready), 32'h1);
            if (k == 2) begin
                base_addr = 32'h500; word_count = 16'd5; start = 1'b1;
                tick();
                start = 1'b0;
                check("t3_start_ign", 32'(busy), 32'h1);
            end
            send_byte(bv);
            if (k == 2) begin
                check("t3_nowr_early", 32'(wr_addr_q.size()), 32'h0);
                check("t3_we_low", 32'(dbg_we), 32'h0);
            end
        end
        wait_done("t3_done");
        check("t3_ww", 32'(words_written), 32'h1);
        check("t3_nwr", 32'(wr_addr_q.size()), 32'h1);
        check_write("t3_w0", 0, 32'h100, 32'h54535251);

        // Address wrap
        clear_log();
        do_start(32'hFFFFFFFC, 16'd2);
        send_word(32'hCAFEF00D);
        send_word(32'h12345678);
        wait_done("t4_done");
        check_write("t4_w0", 0, 32'hFFFFFFFC, 32'hCAFEF00D);
        check_write("t4_w1", 1, 32'h00000000, 32'h12345678);

        // Reset mid-load after two bytes of word 1
        clear_log();
        do_start(32'h40, 16'd2);
        send_word(32'h0BADBEEF);
        send_byte(8'hEE);
        send_byte(8'hFF);
        rst_n = 1'b0;
        #1;
        check("t5_we", 32'(dbg_we), 32'h0);
        check("t5_hold", 32'(cpu_hold), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        #20;
        rst_n = 1'b1;
        tick();
        check("t5_ww", 32'(words_written), 32'h0);
        check("t5_ready", 32'(in_ready), 32'h0);
        check("t5_done", 32'(done), 32'h0);
        check("t5_nwr", 32'(wr_addr_q.size()), 32'h1);
        clear_log();
        do_start(32'h80, 16'd1);
        send_word(32'h04030201);
        // Reset landing inside the WRITE cycle must kill the strobe at once
        check("t5_we_on", 32'(dbg_we), 32'hF);
        rst_n = 1'b0;
        #1;
        check("t5_we_async", 32'(dbg_we), 32'h0);
        #20;
        rst_n = 1'b1;
        tick();
        check("t5_idle_busy", 32'(busy), 32'h0);

`ifdef IMEM_LOADER_VERIFY_EN
        // Readback mismatch at 0x24
        clear_log();
        corrupt_en = 1'b1;
        do_start(32'h20, 16'd3);
        send_word(32'h11111111);
        send_word(32'h22222222);
        begin
            int n = 0;
            while (!error && n < 40) begin
                tick();
                n++;
            end
        end
        check("t6_error", 32'(error), 32'h1);
        check("t6_err_addr", err_addr, 32'h24);
        check("t6_ww", 32'(words_written), 32'h2);
        check("t6_hold", 32'(cpu_hold), 32'h1);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_done", 32'(done), 32'h0);
        check("t6_ready", 32'(in_ready), 32'h0);
        corrupt_en = 1'b0;
        do_start(32'h20, 16'd3);
        check("t6_err_clr", 32'(error), 32'h0);
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        wait_done("t6_clean_done");
        check("t6_clean_err", 32'(error), 32'h0);
        check("t6_clean_addr", err_addr, 32'h0);
        check("t6_clean_ww", 32'(words_written), 32'h3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
